// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: elastic valid/ready pipeline register with optional skid entry,
// synchronous flush, and per-beat late-data merge into the head entry.
`default_nettype none

module pipe_stage_elastic #(
    parameter int DATA_W  = 32,
    parameter int LATE_W  = 32,
    parameter bit SKID_EN = 1'b1
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_late_req,
    input  logic              late_valid,
    input  logic [LATE_W-1:0] late_data,
    output logic              req_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [LATE_W-1:0] out_late
);

    logic              head_v_q,     head_v_d;
    logic [DATA_W-1:0] head_data_q,  head_data_d;
    logic              head_lreq_q,  head_lreq_d;
    logic              head_ldone_q, head_ldone_d;
    logic [LATE_W-1:0] head_late_q,  head_late_d;
    logic              skid_v_q,     skid_v_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic              skid_lreq_q,  skid_lreq_d;

    logic pop;
    logic push;

    assign req_out   = head_v_q & head_lreq_q & ~head_ldone_q;
    assign out_valid = head_v_q & (~head_lreq_q | head_ldone_q);
    assign out_data  = head_data_q;
    assign out_late  = head_late_q;
    assign pop       = out_valid & out_ready;
    assign push      = in_valid & in_ready;

    // With a skid entry, in_ready is purely registered; without one it looks through pop.
    generate
        if (SKID_EN) begin : g_skid
            assign in_ready = ~skid_v_q;
        end else begin : g_no_skid
            assign in_ready = ~head_v_q | pop;
        end
    endgenerate

    always_comb begin
        head_v_d     = head_v_q;
        head_data_d  = head_data_q;
        head_lreq_d  = head_lreq_q;
        head_ldone_d = head_ldone_q;
        head_late_d  = head_late_q;
        skid_v_d     = skid_v_q;
        skid_data_d  = skid_data_q;
        skid_lreq_d  = skid_lreq_q;

        if (flush) begin
            head_v_d     = 1'b0;
            head_data_d  = '0;
            head_lreq_d  = 1'b0;
            head_ldone_d = 1'b0;
            head_late_d  = '0;
            skid_v_d     = 1'b0;
            skid_data_d  = '0;
            skid_lreq_d  = 1'b0;
        end else begin
            // A waiting head can never pop, so capture and pop never collide.
            if (late_valid && req_out) begin
                head_late_d  = late_data;
                head_ldone_d = 1'b1;
            end
            if (pop) begin
                if (skid_v_q) begin
                    head_v_d     = 1'b1;
                    head_data_d  = skid_data_q;
                    head_lreq_d  = skid_lreq_q;
                    head_ldone_d = 1'b0;
                    head_late_d  = '0;
                    skid_v_d     = 1'b0;
                    skid_data_d  = '0;
                    skid_lreq_d  = 1'b0;
                end else if (push) begin
                    head_v_d     = 1'b1;
                    head_data_d  = in_data;
                    head_lreq_d  = in_late_req;
                    head_ldone_d = 1'b0;
                    head_late_d  = '0;
                end else begin
                    head_v_d     = 1'b0;
                    head_data_d  = '0;
                    head_lreq_d  = 1'b0;
                    head_ldone_d = 1'b0;
                    head_late_d  = '0;
                end
            end else if (push) begin
                if (!head_v_q) begin
                    head_v_d     = 1'b1;
                    head_data_d  = in_data;
                    head_lreq_d  = in_late_req;
                    head_ldone_d = 1'b0;
                    head_late_d  = '0;
                end else if (SKID_EN) begin
                    skid_v_d    = 1'b1;
                    skid_data_d = in_data;
                    skid_lreq_d = in_late_req;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            head_v_q     <= 1'b0;
            head_data_q  <= '0;
            head_lreq_q  <= 1'b0;
            head_ldone_q <= 1'b0;
            head_late_q  <= '0;
            skid_v_q     <= 1'b0;
            skid_data_q  <= '0;
            skid_lreq_q  <= 1'b0;
        end else begin
            head_v_q     <= head_v_d;
            head_data_q  <= head_data_d;
            head_lreq_q  <= head_lreq_d;
            head_ldone_q <= head_ldone_d;
            head_late_q  <= head_late_d;
            skid_v_q     <= skid_v_d;
            skid_data_q  <= skid_data_d;
            skid_lreq_q  <= skid_lreq_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_elastic.sv
// tb_pipe_stage_elastic: directed and random stimulus applied to a skid (u1) and a
// head-only (u0) instance, each checked against a queue-based beat model.
`default_nettype none

module tb_pipe_stage_elastic;

    typedef struct {
        logic [31:0] d;
        logic        lreq;
        logic        ldone;
        logic [31:0] late;
    } beat_t;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_late_req = 1'b0;
    logic        late_valid = 1'b0;
    logic [31:0] late_data = '0;
    logic        out_ready = 1'b0;

    logic        in_ready1, req_out1, out_valid1;
    logic [31:0] out_data1, out_late1;
    logic        in_ready0, req_out0, out_valid0;
    logic [31:0] out_data0, out_late0;

    pipe_stage_elastic #(.DATA_W(32), .LATE_W(32), .SKID_EN(1'b1)) u1 (
        .CLK(CLK), .nRST(nRST), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .in_late_req(in_late_req), .late_valid(late_valid), .late_data(late_data),
        .req_out(req_out1), .out_valid(out_valid1), .out_ready(out_ready),
        .out_data(out_data1), .out_late(out_late1)
    );

    pipe_stage_elastic #(.DATA_W(32), .LATE_W(32), .SKID_EN(1'b0)) u0 (
        .CLK(CLK), .nRST(nRST), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .in_late_req(in_late_req), .late_valid(late_valid), .late_data(late_data),
        .req_out(req_out0), .out_valid(out_valid0), .out_ready(out_ready),
        .out_data(out_data0), .out_late(out_late0)
    );

    always #5 CLK = ~CLK;

    int    checks = 0;
    int    passed = 0;
    beat_t q1[$];
    beat_t q0[$];
    bit    pushed1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    // Expected outputs from model occupancy and the oldest beat.
    function automatic void model_out(input int n, input beat_t h, input bit skid,
                                      output logic ov, output logic rq, output logic ir,
                                      output logic [31:0] od, output logic [31:0] ol);
        if (n == 0) begin
            ov = 1'b0; rq = 1'b0; od = '0; ol = '0;
        end else begin
            ov = !h.lreq || h.ldone;
            rq = h.lreq && !h.ldone;
            od = h.d;
            ol = h.late;
        end
        ir = skid ? (n < 2) : (n == 0 || (ov && out_ready));
    endfunction

    // Called just after a falling edge with inputs applied; returns at the next falling edge.
    task automatic step();
        logic ov, rq, ir;
        logic [31:0] od, ol;
        beat_t h, nb, z;
        z = '{32'h0, 1'b0, 1'b0, 32'h0};
        nb = '{in_data, in_late_req, 1'b0, 32'h0};
        #1;
        h = (q1.size() > 0) ? q1[0] : z;
        model_out(q1.size(), h, 1'b1, ov, rq, ir, od, ol);
        chk("u1.out_valid", {31'b0, out_valid1}, {31'b0, ov});
        chk("u1.req_out",   {31'b0, req_out1},   {31'b0, rq});
        chk("u1.in_ready",  {31'b0, in_ready1},  {31'b0, ir});
        chk("u1.out_data",  out_data1, od);
        chk("u1.out_late",  out_late1, ol);
        pushed1 = in_valid && ir;
        if (flush) q1.delete();
        else begin
            if (rq && late_valid) begin q1[0].late = late_data; q1[0].ldone = 1'b1; end
            if (ov && out_ready) void'(q1.pop_front());
            if (in_valid && ir) q1.push_back(nb);
        end

        h = (q0.size() > 0) ? q0[0] : z;
        model_out(q0.size(), h, 1'b0, ov, rq, ir, od, ol);
        chk("u0.out_valid", {31'b0, out_valid0}, {31'b0, ov});
        chk("u0.req_out",   {31'b0, req_out0},   {31'b0, rq});
        chk("u0.in_ready",  {31'b0, in_ready0},  {31'b0, ir});
        chk("u0.out_data",  out_data0, od);
        chk("u0.out_late",  out_late0, ol);
        if (flush) q0.delete();
        else begin
            if (rq && late_valid) begin q0[0].late = late_data; q0[0].ldone = 1'b1; end
            if (ov && out_ready) void'(q0.pop_front());
            if (in_valid && ir) q0.push_back(nb);
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        int guard;
        @(negedge CLK);
        @(negedge CLK);
        #1;
        chk("rst.out_valid", {31'b0, out_valid1}, 32'd0);
        chk("rst.req_out",   {31'b0, req_out1},   32'd0);
        chk("rst.out_data",  out_data1, 32'd0);
        chk("rst.out_late",  out_late1, 32'd0);
        chk("rst.in_ready",  {31'b0, in_ready1},  32'd1);
        @(negedge CLK);
        nRST = 1'b1;

        // Streaming
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_data = i;
            step();
        end
        in_valid = 1'b0;
        step(); step();

        // Backpressure
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hA; step();
        in_data = 32'hB; step();
        in_data = 32'hC; step();
        #1 chk("bp.hold_data", out_data1, 32'hA);
        chk("bp.in_ready", {31'b0, in_ready1}, 32'd0);
        step();
        out_ready = 1'b1;
        guard = 0;
        do begin step(); guard++; end while (!pushed1 && guard < 10);
        chk("bp.c_accepted", {31'b0, pushed1}, 32'd1);
        in_valid = 1'b0;
        repeat (4) step();

        // Late data
        in_valid = 1'b1; in_data = 32'h10; in_late_req = 1'b1; step();
        in_valid = 1'b0; in_late_req = 1'b0;
        step(); step();
        late_valid = 1'b1; late_data = 32'hDEAD; step();
        late_valid = 1'b0;
        #1 chk("late.out_valid", {31'b0, out_valid1}, 32'd1);
        chk("late.out_late", out_late1, 32'hDEAD);
        chk("late.req_out", {31'b0, req_out1}, 32'd0);
        step(); step();

        // Late then skid
        in_valid = 1'b1; in_data = 32'h20; in_late_req = 1'b1; step();
        in_data = 32'h21; step();
        in_valid = 1'b0; in_late_req = 1'b0;
        late_valid = 1'b1; late_data = 32'hBEEF; step();
        late_valid = 1'b0; step();
        #1 chk("skid.head_data", out_data1, 32'h21);
        chk("skid.out_late", out_late1, 32'd0);
        chk("skid.req_out", {31'b0, req_out1}, 32'd1);
        late_valid = 1'b1; late_data = 32'h55; step();
        late_valid = 1'b0; step(); step();

        // Flush in TWO with simultaneous push and late
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h30; in_late_req = 1'b1; step();
        in_data = 32'h31; in_late_req = 1'b0; step();
        flush = 1'b1; in_data = 32'h32; late_valid = 1'b1; late_data = 32'h77; step();
        flush = 1'b0; in_valid = 1'b0; late_valid = 1'b0;
        #1 chk("flush.out_valid", {31'b0, out_valid1}, 32'd0);
        chk("flush.req_out", {31'b0, req_out1}, 32'd0);
        chk("flush.out_data", out_data1, 32'd0);
        chk("flush.in_ready", {31'b0, in_ready1}, 32'd1);
        step();

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            in_valid    = ($urandom_range(0, 1) == 1);
            in_data     = $urandom;
            in_late_req = ($urandom_range(0, 9) < 3);
            late_valid  = ($urandom_range(0, 9) < 3);
            late_data   = $urandom;
            out_ready   = ($urandom_range(0, 9) < 7);
            flush       = ($urandom_range(0, 99) < 3);
            step();
        end
        flush = 1'b0; late_valid = 1'b0;

        // Async reset mid-stream
        in_valid = 1'b1; in_data = 32'h40; in_late_req = 1'b0; out_ready = 1'b0;
        step();
        in_data = 32'h41; step();
        #2 nRST = 1'b0;
        #1;
        chk("arst.u1.out_valid", {31'b0, out_valid1}, 32'd0);
        chk("arst.u1.out_data", out_data1, 32'd0);
        chk("arst.u1.in_ready", {31'b0, in_ready1}, 32'd1);
        chk("arst.u0.out_valid", {31'b0, out_valid0}, 32'd0);
        chk("arst.u0.req_out", {31'b0, req_out0}, 32'd0);
        chk("arst.u0.out_late", out_late0, 32'd0);
        chk("arst.u0.in_ready", {31'b0, in_ready0}, 32'd1);
        q1.delete();
        q0.delete();
        in_valid = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        in_valid = 1'b1; in_data = 32'h50; step();
        in_valid = 1'b0; out_ready = 1'b1; step(); step();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
